// File: rtl/serial_send_if.sv
// Word handshake between a data source (master) and serial_send (slave).
interface serial_send_if;
   localparam int unsigned WORD_W = 16;

   logic [WORD_W-1:0] din;
   logic              din_valid;
   logic              din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_send.sv
// 2-bit-per-cycle serializer for the LVDS link: 2-entry word FIFO, 8-cycle word slots,
// frame strobe, training/idle insertion. Define SERIAL_SEND_PRBS_EN for PRBS15 idle words.
module serial_send (
   input  logic         clks,
   input  logic         rsts,
   input  logic         phy_init,
   serial_send_if.slave bus,
   output logic         dout_r,
   output logic         dout_f,
   output logic         frame,
   output logic         idle
);
   localparam int unsigned WORD_W = 16;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned OCC_W  = 2;
   localparam logic [WORD_W-1:0] TRAIN_WORD = 16'hAAAA;
   localparam logic [WORD_W-1:0] IDLE_WORD  = 16'hF00F;

   typedef enum logic [1:0] {
      SRC_TRAIN,
      SRC_FIFO,
      SRC_IDLE
   } src_e;

   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              load;
   logic [WORD_W-1:0] sreg;
   logic [WORD_W-1:0] mem [DEPTH];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [OCC_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   src_e              src;
   logic [WORD_W-1:0] load_word;
   logic [WORD_W-1:0] idle_word;

   assign cnt_next      = cnt + CNT_W'(1);
   assign load          = (cnt == CNT_W'(7));
   assign full          = (count == OCC_W'(DEPTH));
   assign empty         = (count == OCC_W'(0));
   assign bus.din_ready = !full;
   assign push          = bus.din_valid && !full;
   assign pop           = load && (src == SRC_FIFO);

`ifdef SERIAL_SEND_PRBS_EN
   localparam int unsigned LFSR_W = 15;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;

   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] lfsr_next;
   logic [WORD_W-1:0] prbs_word;

   // Sixteen PRBS15 steps (x^15+x^14+1), first generated bit lands in the MSB.
   always_comb begin
      logic fb;
      fb        = 1'b0;
      lfsr_next = lfsr;
      prbs_word = '0;
      for (int i = 0; i < int'(WORD_W); i++) begin
         fb        = lfsr_next[14] ^ lfsr_next[13];
         prbs_word = {prbs_word[WORD_W-2:0], fb};
         lfsr_next = {lfsr_next[LFSR_W-2:0], fb};
      end
   end

   // Sequence only advances when an idle word is actually sent.
   always_ff @(posedge clks or posedge rsts) begin
      if (rsts) begin
         lfsr <= LFSR_SEED;
      end else if (load && (src == SRC_IDLE)) begin
         lfsr <= lfsr_next;
      end
   end

   assign idle_word = prbs_word;
`else
   assign idle_word = IDLE_WORD;
`endif

   // Slot-load priority: training, then queued data, then idle filler.
   always_comb begin
      src       = SRC_FIFO;
      load_word = mem[rd_ptr];
      if (phy_init) begin
         src       = SRC_TRAIN;
         load_word = TRAIN_WORD;
      end else if (empty) begin
         src       = SRC_IDLE;
         load_word = idle_word;
      end
   end

   // Two-entry FIFO; simultaneous push/pop leaves occupancy unchanged.
   always_ff @(posedge clks or posedge rsts) begin
      if (rsts) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= bus.din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + OCC_W'(1);
            2'b01:   count <= count - OCC_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot counter, shift register and strobes; reset makes the first edge a load edge.
   always_ff @(posedge clks or posedge rsts) begin
      if (rsts) begin
         cnt   <= CNT_W'(7);
         sreg  <= '0;
         frame <= 1'b0;
         idle  <= 1'b0;
      end else begin
         cnt   <= cnt_next;
         frame <= (cnt_next < CNT_W'(4));
         if (load) begin
            sreg <= load_word;
            idle <= (src == SRC_IDLE);
         end else begin
            sreg <= {sreg[WORD_W-3:0], 2'b00};
            idle <= 1'b0;
         end
      end
   end

   assign dout_r = sreg[WORD_W-1];
   assign dout_f = sreg[WORD_W-2];
endmodule

// File: tb/tb_serial_send.sv
// Self-checking bench for serial_send: word-level reference model plus directed and random scenarios.
module tb_serial_send;
   logic clks = 1'b0;
   logic rsts;
   logic phy_init;
   logic dout_r;
   logic dout_f;
   logic frame;
   logic idle;

   serial_send_if bus ();

   serial_send dut (
      .clks     (clks),
      .rsts     (rsts),
      .phy_init (phy_init),
      .bus      (bus),
      .dout_r   (dout_r),
      .dout_f   (dout_f),
      .frame    (frame),
      .idle     (idle)
   );

   always #5 clks = ~clks;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: word queue, current slot word, position within slot.
   logic [15:0] m_q [$];
   logic [15:0] m_cur;
   logic [15:0] m_din;
   logic        m_push;
   logic        m_started = 1'b0;
   int          m_nxt = 0;
   int          m_p;
   logic        exp_r, exp_f, exp_frame, exp_idle, exp_ready;
   bit          hist [$];

   function automatic logic [15:0] model_idle_word();
`ifdef SERIAL_SEND_PRBS_EN
      logic [15:0] w;
      bit b;
      w = '0;
      for (int i = 0; i < 16; i++) begin
         b = hist[0] ^ hist[1];
         void'(hist.pop_front());
         hist.push_back(b);
         w = {w[14:0], b};
      end
      return w;
`else
      return 16'hF00F;
`endif
   endfunction

   // k-th idle word of a fresh sequence, computed from the bit recurrence directly.
   function automatic logic [15:0] exp_idle_word(input int k);
`ifdef SERIAL_SEND_PRBS_EN
      bit seq [$];
      logic [15:0] w;
      w = '0;
      repeat (15) seq.push_back(1'b1);
      for (int n = 0; n < 16 * (k + 1); n++) seq.push_back(seq[n] ^ seq[n+1]);
      for (int i = 0; i < 16; i++) w = {w[14:0], seq[15 + 16*k + i]};
      return w;
`else
      return (k >= 0) ? 16'hF00F : 16'h0000;
`endif
   endfunction

   always @(posedge clks or posedge rsts) begin
      if (rsts) begin
         m_q.delete();
         m_nxt     = 0;
         m_started = 1'b0;
         m_cur     = '0;
         exp_r     = 1'b0;
         exp_f     = 1'b0;
         exp_frame = 1'b0;
         exp_idle  = 1'b0;
         exp_ready = 1'b1;
         hist.delete();
         repeat (15) hist.push_back(1'b1);
      end else begin
         m_p      = m_nxt;
         m_push   = bus.din_valid && (m_q.size() < 2);
         m_din    = bus.din;
         exp_idle = 1'b0;
         if (m_p == 0) begin
            if (phy_init)              m_cur = 16'hAAAA;
            else if (m_q.size() > 0)   m_cur = m_q.pop_front();
            else begin
               m_cur    = model_idle_word();
               exp_idle = 1'b1;
            end
         end
         if (m_push) m_q.push_back(m_din);
         exp_r     = m_cur[15 - 2*m_p];
         exp_f     = m_cur[14 - 2*m_p];
         exp_frame = (m_p < 4);
         exp_ready = (m_q.size() < 2);
         m_nxt     = (m_p + 1) % 8;
         m_started = 1'b1;
      end
   end

   // Rebuild each transmitted word from the pair stream, slot-aligned.
   logic [15:0] mon_w;
   logic        mon_idle;
   logic [15:0] cap_q [$];
   bit          cap_idle [$];
   int          mon_pos;

   always @(negedge clks) begin
      if (!rsts && m_started) begin
         mon_pos = (m_nxt + 7) % 8;
         if (mon_pos == 0) begin
            mon_w    = '0;
            mon_idle = idle;
         end
         mon_w = {mon_w[13:0], dout_r, dout_f};
         if (mon_pos == 7) begin
            cap_q.push_back(mon_w);
            cap_idle.push_back(mon_idle);
         end
      end
   end

   task automatic tick();
      @(negedge clks);
      #1;
   endtask

   task automatic align(input int nxt);
      int g;
      g = 0;
      while (m_nxt != nxt && g < 16) begin
         tick();
         g++;
      end
      if (m_nxt != nxt) begin
         n_checks++;
         $display("FAIL align: slot position %0d, required %0d", m_nxt, nxt);
      end
   endtask

   task automatic test_reset();
      logic [15:0] w;
      rsts          = 1'b1;
      phy_init      = 1'b0;
      bus.din_valid = 1'b0;
      bus.din       = '0;
      repeat (3) tick();
      n_checks++;
      if ({dout_r, dout_f, frame, idle, bus.din_ready} !== 5'b00001)
         $display("FAIL reset_values: got %b required 00001", {dout_r, dout_f, frame, idle, bus.din_ready});
      else n_pass++;
      rsts = 1'b0;
      tick();
      w = exp_idle_word(0);
      n_checks++;
      if ({frame, idle} !== 2'b11) $display("FAIL first_load_strobes: got %b required 11", {frame, idle});
      else n_pass++;
      n_checks++;
      if ({dout_r, dout_f} !== w[15:14]) $display("FAIL first_load_pair: got %b required %b", {dout_r, dout_f}, w[15:14]);
      else n_pass++;
   endtask

   task automatic test_idle();
      int pulses;
      logic [4:0] obs, exv;
      rsts = 1'b1;
      tick();
      rsts = 1'b0;
      cap_q.delete();
      cap_idle.delete();
      pulses = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         obs = {dout_r, dout_f, frame, idle, bus.din_ready};
         exv = {exp_r, exp_f, exp_frame, exp_idle, exp_ready};
         n_checks++;
         if (obs !== exv) $display("FAIL idle_cycle%0d: got %b required %b", c, obs, exv);
         else n_pass++;
         if (idle) pulses++;
      end
      n_checks++;
      if (pulses != 3) $display("FAIL idle_pulse_count: got %0d required 3", pulses);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (cap_q[k] !== exp_idle_word(k) || cap_idle[k] !== 1'b1)
            $display("FAIL idle_word%0d: got %h/%b required %h/1", k, cap_q[k], cap_idle[k], exp_idle_word(k));
         else n_pass++;
      end
   endtask

   task automatic test_train();
      phy_init      = 1'b1;
      bus.din_valid = 1'b1;
      bus.din       = 16'h1234;
      tick();
      bus.din_valid = 1'b0;
      n_checks++;
      if (bus.din_ready !== 1'b1) $display("FAIL train_ready: got %b required 1", bus.din_ready);
      else n_pass++;
      align(0);
      cap_q.delete();
      cap_idle.delete();
      repeat (16) tick();
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (cap_q[k] !== 16'hAAAA || cap_idle[k] !== 1'b0)
            $display("FAIL train_word%0d: got %h/%b required aaaa/0", k, cap_q[k], cap_idle[k]);
         else n_pass++;
      end
      phy_init = 1'b0;
      repeat (8) tick();
      n_checks++;
      if (cap_q[2] !== 16'h1234) $display("FAIL train_release_word: got %h required 1234", cap_q[2]);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [3];
      logic [15:0] req;
      int idx, t;
      logic ready_before, stalled;
      words[0] = 16'hFFFF;
      words[1] = 16'h0000;
      words[2] = 16'h8001;
      align(0);
      cap_q.delete();
      cap_idle.delete();
      idx = 0;
      t = 0;
      stalled = 1'b0;
      bus.din_valid = 1'b1;
      bus.din       = words[0];
      while (idx < 3 && t < 40) begin
         ready_before = bus.din_ready;
         tick();
         t++;
         if (ready_before) begin
            idx++;
            if (idx < 3) bus.din = words[idx];
            else bus.din_valid = 1'b0;
         end
         if (idx == 2 && !bus.din_ready) stalled = 1'b1;
      end
      bus.din_valid = 1'b0;
      n_checks++;
      if (idx != 3) $display("FAIL b2b_push_timeout: pushed %0d required 3", idx);
      else n_pass++;
      n_checks++;
      if (stalled !== 1'b1) $display("FAIL b2b_stall: got %b required 1", stalled);
      else n_pass++;
      while (t < 32) begin
         tick();
         t++;
      end
      for (int k = 0; k < 3; k++) begin
         req = words[k];
         n_checks++;
         if (cap_q[k+1] !== req || cap_idle[k+1] !== 1'b0)
            $display("FAIL b2b_word%0d: got %h/%b required %h/0", k, cap_q[k+1], cap_idle[k+1], req);
         else n_pass++;
      end
   endtask

   task automatic test_same_cycle();
      align(2);
      bus.din_valid = 1'b1;
      bus.din       = 16'hA5A5;
      tick();
      bus.din_valid = 1'b0;
      align(0);
      cap_q.delete();
      cap_idle.delete();
      bus.din_valid = 1'b1;
      bus.din       = 16'h5A5A;
      tick();
      n_checks++;
      if (bus.din_ready !== 1'b1) $display("FAIL same_cycle_occ1: got %b required 1", bus.din_ready);
      else n_pass++;
      bus.din = 16'h3C3C;
      tick();
      bus.din_valid = 1'b0;
      n_checks++;
      if (bus.din_ready !== 1'b0) $display("FAIL same_cycle_occ2: got %b required 0", bus.din_ready);
      else n_pass++;
      repeat (22) tick();
      n_checks++;
      if (cap_q.size() < 3 || cap_q[0] !== 16'hA5A5 || cap_q[1] !== 16'h5A5A || cap_q[2] !== 16'h3C3C)
         $display("FAIL same_cycle_order: got %h %h %h required a5a5 5a5a 3c3c", cap_q[0], cap_q[1], cap_q[2]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      align(1);
      bus.din_valid = 1'b1;
      bus.din       = 16'h1111;
      tick();
      bus.din       = 16'h2222;
      tick();
      bus.din_valid = 1'b0;
      tick();
      n_checks++;
      if ({frame, bus.din_ready} !== 2'b10) $display("FAIL mid_pre_reset: got %b required 10", {frame, bus.din_ready});
      else n_pass++;
      rsts = 1'b1;
      #1;
      n_checks++;
      if ({dout_r, dout_f, frame, idle, bus.din_ready} !== 5'b00001)
         $display("FAIL mid_async_reset: got %b required 00001", {dout_r, dout_f, frame, idle, bus.din_ready});
      else n_pass++;
      tick();
      rsts = 1'b0;
      cap_q.delete();
      cap_idle.delete();
      repeat (8) tick();
      n_checks++;
      if (cap_q[0] !== exp_idle_word(0) || cap_idle[0] !== 1'b1)
         $display("FAIL mid_first_slot: got %h/%b required %h/1", cap_q[0], cap_idle[0], exp_idle_word(0));
      else n_pass++;
   endtask

   task automatic test_idle_insert();
      rsts = 1'b1;
      tick();
      rsts = 1'b0;
      cap_q.delete();
      cap_idle.delete();
      bus.din_valid = 1'b1;
      bus.din       = 16'hDDDD;
      tick();
      bus.din_valid = 1'b0;
      repeat (23) tick();
      n_checks++;
      if (cap_q[0] !== exp_idle_word(0) || cap_idle[0] !== 1'b1)
         $display("FAIL insert_idle0: got %h/%b required %h/1", cap_q[0], cap_idle[0], exp_idle_word(0));
      else n_pass++;
      n_checks++;
      if (cap_q[1] !== 16'hDDDD || cap_idle[1] !== 1'b0)
         $display("FAIL insert_data: got %h/%b required dddd/0", cap_q[1], cap_idle[1]);
      else n_pass++;
      n_checks++;
      if (cap_q[2] !== exp_idle_word(1) || cap_idle[2] !== 1'b1)
         $display("FAIL insert_idle1: got %h/%b required %h/1", cap_q[2], cap_idle[2], exp_idle_word(1));
      else n_pass++;
   endtask

   task automatic test_random();
      logic [4:0] obs, exv;
      int bad;
      bad = 0;
      for (int c = 0; c < 800; c++) begin
         bus.din_valid = ($urandom_range(0, 99) < 60);
         bus.din       = 16'($urandom);
         if ($urandom_range(0, 99) < 4) phy_init = ~phy_init;
         tick();
         obs = {dout_r, dout_f, frame, idle, bus.din_ready};
         exv = {exp_r, exp_f, exp_frame, exp_idle, exp_ready};
         n_checks++;
         if (obs !== exv) begin
            if (bad < 10) $display("FAIL random_cycle%0d: got %b required %b", c, obs, exv);
            bad++;
         end else n_pass++;
      end
      bus.din_valid = 1'b0;
      phy_init      = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_train();
      test_back_to_back();
      test_same_cycle();
      test_reset_mid();
      test_idle_insert();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/serial_send.md
# serial_send

Transmit-side counterpart of the 2-bit-per-cycle LVDS serial link. Accepts 16-bit words over a valid/ready handshake, buffers up to two, and serializes each word MSB-first as one bit pair per CLKS cycle (rising-half bit, falling-half bit) over an 8-cycle word slot. It also generates the word-frame strobe and inserts training or idle words. The pair outputs drive an external ODDR2/OBUFDS pair; the frame strobe is the far end's word-boundary marker.

## Interface
- TRAIN_WORD, 16'hAAAA: word sent in every slot while PHY_INIT is sampled high.
- IDLE_WORD, 16'hF00F: word sent when the buffer is empty (macro off).

- CLKS  in  1  serial word clock; all logic on posedge.
- RSTS  in  1  reset; asynchronous, active-high.
- PHY_INIT  in  1  link training request; sampled only at slot load.
- DIN  in  16  word to transmit.
- DIN_VALID  in  1  DIN valid.
- DIN_READY  out  1  buffer can accept; high when fewer than 2 entries.
- DOUT_R  out  1  bit for rising half of the current cycle (ODDR2 D0).
- DOUT_F  out  1  bit for falling half of the current cycle (ODDR2 D1).
- FRAME  out  1  word-frame strobe; high for slot cycles 0–3, low for 4–7.
- IDLE  out  1  one-cycle pulse on a load edge that loaded an idle word (not a training word).

## Operation
- Buffer: 2-entry FIFO. A push occurs when DIN_VALID && DIN_READY. DIN_READY is combinational from occupancy: `!full`.
- Slot counter `cnt[2:0]` increments modulo 8 every cycle. The edge where `cnt` goes 7→0 is the load edge.
- Load priority at the load edge:
  1. PHY_INIT=1 → load TRAIN_WORD. The FIFO is not popped.
  2. Otherwise, if the FIFO is non-empty → pop the head and load it.
  3. Otherwise → load the idle word and pulse IDLE.
- Serialization: for the word W loaded at slot cycle k (0..7), DOUT_R = W[15-2k] and DOUT_F = W[14-2k]. Bit 15 goes first.
- Outputs are registered from a 16-bit shift register. On the load edge the register takes W and the outputs take W[15:14]. On each following edge it shifts left by 2.
- Push and pop may occur in the same cycle (only possible with occupancy 1). Occupancy is then unchanged and ordering is preserved.
- A word pushed on the load edge itself is not bypassed. It waits for the next load edge.
- PHY_INIT changing mid-slot has no effect on the word in flight.

## Timing
- Reset values: `cnt`=7, shift register 0, DOUT_R=0, DOUT_F=0, FRAME=0, IDLE=0, FIFO empty, DIN_READY=1. LFSR is set to 15'h7FFF when the macro is on.
- The first clock edge after RSTS deasserts is a load edge.
- FRAME is registered and rises on the same edge that presents W[15:14].
- Latency: a word pushed at edge t first appears on DOUT at the first load edge strictly after t. That is 1–8 cycles with an empty FIFO, or up to 16 cycles behind one queued word.
- Throughput: one word per 8 cycles. With a continuous source, DIN_READY toggles once the FIFO has filled.
- RSTS asserted mid-slot immediately forces all reset values. The FIFO contents and the word in flight are discarded, with no partial-word completion.

## Configuration
- SERIAL_SEND_PRBS_EN defined: the idle word is the next 16 bits of PRBS15 (x^15+x^14+1, seed 15'h7FFF), taken MSB-first. The LFSR advances 16 steps only on loads of idle words, not on data or training words. IDLE_WORD is ignored.
- Not defined: the idle word is the constant IDLE_WORD and there is no LFSR logic.

## Test plan
- Reset release, no input, PHY_INIT=0, macro off → DOUT_R/DOUT_F repeat pairs 11,11,00,00,00,00,11,11 every 8 cycles (16'hF00F). FRAME pattern is 11110000. IDLE pulses on every load edge.
- PHY_INIT=1 with 16'h1234 pushed → only pairs 10,10,10,10 (16'hAAAA) are sent. DIN_READY stays 1 after one push. After PHY_INIT drops, the next slot carries pairs 00,01,00,10,00,11,01,00 (16'h1234).
- Three back-to-back pushes 16'hFFFF, 16'h0000, 16'h8001 → third push stalls (DIN_READY=0) until the next load. Words appear in order on consecutive slots with no IDLE pulse between them.
- Push and pop on the same load edge at occupancy 1 → occupancy stays 1. No word is lost or duplicated.
- RSTS asserted at slot cycle 3 with 2 words queued → outputs go to 0 asynchronously and DIN_READY=1. After release, the first slot is idle, not a queued word.
- Macro on, idle for 2 slots → the two words match the software PRBS15 model from seed 7FFF. A data word inserted between them does not advance the sequence.
